stick_overlay_renderer: RTL

- Parametrised successor to the input viewer's two-stick overlay. Renders NUM_STICKS analogue-stick sprites that move with stick deflection.
- Adds multi-frame averaged centre calibration, a deadzone, offset clamping, tear-free frame-synchronous position updates and a fixed 2-cycle pixel pipeline.
- Sits between the controller decoder (axis inputs) and the VGA pixel mux. Sprite ROMs stay outside the block and are reached through flattened address/data ports.

---
 rtl/stick_overlay_pkg.sv | 20 ++
 rtl/stick_axis_offset.sv | 108 ++++++++++
 rtl/stick_overlay_renderer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/stick_overlay_pkg.sv
// Shared definitions for the analogue-stick overlay: FSM encoding, colour
// keys, coordinate width and packed-vector field extraction.

// Pull the 10-bit field for stick idx out of a packed per-stick vector.
`define SO_FIELD10(vec, idx) vec[(idx)*10 +: 10]

package stick_overlay_pkg;

    localparam int COORD_W = 10;

    localparam logic [11:0] COLOR_TRANSPARENT = 12'h000;
    localparam logic [11:0] COLOR_CUTOUT      = 12'h888;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_CAL_WAIT = 2'd1,
        ST_CAL_ACC  = 2'd2
    } cal_state_e;

endpackage

// File: rtl/stick_axis_offset.sv
// One stick axis: centre register, calibration accumulator, deadzone /
// scale / clamp and the frame-synchronous sprite edge position.
// NEG_ON_HIGH selects the screen direction: 0 for x (right is positive),
// 1 for y (a high reading moves the sprite up, i.e. to a smaller row).

module stick_axis_offset
    import stick_overlay_pkg::*;
#(
    parameter int                 AXIS_W      = 8,
    parameter int                 DEADZONE    = 4,
    parameter int                 MAX_OFF     = 40,
    parameter int                 CAL_LOG2    = 4,
    parameter logic [COORD_W-1:0] HOME        = 10'd0,
    parameter bit                 NEG_ON_HIGH = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start_i,
    input  cal_state_e         state_i,
    input  logic               cal_last_i,
    input  logic [AXIS_W-1:0]  raw_i,
    output logic [COORD_W-1:0] pos_o
);

    localparam int ACC_W = AXIS_W + CAL_LOG2;
    localparam logic [AXIS_W-1:0] CENTRE_RST = {1'b1, {(AXIS_W-1){1'b0}}};

    logic [AXIS_W-1:0]  centre_q, centre_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum_s;
    logic [COORD_W-1:0] pos_q, pos_d, pos_calc_s;
    logic               high_side_s;
    logic [AXIS_W-1:0]  dev_s, scaled_s;
    logic [COORD_W-1:0] off_s;

    // Deflection magnitude, deadzone, 3/8 scaling and clamp to a pixel offset
    always_comb begin
        high_side_s = (raw_i >= centre_q);
        if (high_side_s) begin
            dev_s = raw_i - centre_q;
        end else begin
            dev_s = centre_q - raw_i;
        end
        if (int'(dev_s) >= DEADZONE) begin
            scaled_s = (dev_s >> 2) + (dev_s >> 3);
        end else begin
            scaled_s = '0;
        end
        if (int'(scaled_s) > MAX_OFF) begin
            off_s = COORD_W'(MAX_OFF);
        end else begin
            off_s = COORD_W'(scaled_s);
        end
        if (high_side_s ^ NEG_ON_HIGH) begin
            pos_calc_s = HOME + off_s;
        end else begin
            pos_calc_s = HOME - off_s;
        end
        acc_sum_s = acc_q + ACC_W'(raw_i);
    end

    // Next state: everything moves only on frame_start; calibrating frames park the sprite at home
    always_comb begin
        centre_d = centre_q;
        acc_d    = acc_q;
        pos_d    = pos_q;
        if (frame_start_i) begin
            case (state_i)
                ST_RUN: begin
                    pos_d = pos_calc_s;
                end
                ST_CAL_WAIT: begin
                    acc_d = '0;
                    pos_d = HOME;
                end
                ST_CAL_ACC: begin
                    acc_d = acc_sum_s;
                    pos_d = HOME;
                    if (cal_last_i) begin
                        centre_d = acc_sum_s[ACC_W-1:CAL_LOG2];
                    end else begin
                        centre_d = centre_q;
                    end
                end
                default: begin
                    pos_d = HOME;
                end
            endcase
        end else begin
            pos_d = pos_q;
        end
    end

    // Centre, accumulator and position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            centre_q <= CENTRE_RST;
            acc_q    <= '0;
            pos_q    <= HOME;
        end else begin
            centre_q <= centre_d;
            acc_q    <= acc_d;
            pos_q    <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/stick_overlay_renderer.sv
// Renders NUM_STICKS analogue-stick sprites that follow stick deflection.
// A shared calibration FSM drives 2*NUM_STICKS axis blocks; the pixel path
// is a fixed two-stage pipeline (address/hit, then ROM colour priority).

module stick_overlay_renderer
    import stick_overlay_pkg::*;
#(
    parameter int                        NUM_STICKS  = 2,
    parameter int                        AXIS_W      = 8,
    parameter logic [NUM_STICKS*10-1:0]  HOME_X_VEC  = {10'd221, 10'd64},
    parameter logic [NUM_STICKS*10-1:0]  HOME_Y_VEC  = {10'd232, 10'd223},
    parameter logic [NUM_STICKS*10-1:0]  SPR_W_VEC   = {10'd52, 10'd70},
    parameter logic [NUM_STICKS*10-1:0]  SPR_H_VEC   = {10'd52, 10'd70},
    parameter int                        DEADZONE    = 4,
    parameter int                        MAX_OFF     = 40,
    parameter int                        CAL_LOG2    = 4,
    parameter logic [11:0]               TRANSPARENT = COLOR_TRANSPARENT,
    parameter logic [11:0]               CUTOUT      = COLOR_CUTOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic [9:0]                    x,
    input  logic [9:0]                    y,
    input  logic [NUM_STICKS*AXIS_W-1:0]  stick_x,
    input  logic [NUM_STICKS*AXIS_W-1:0]  stick_y,
    input  logic                          cal_req,
    output logic [NUM_STICKS*10-1:0]      rom_row,
    output logic [NUM_STICKS*10-1:0]      rom_col,
    input  logic [NUM_STICKS*12-1:0]      rom_data,
    output logic                          cal_busy,
    output logic                          pixel_on,
    output logic                          in_cutout,
    output logic [11:0]                   rgb
);

    cal_state_e           state_q, state_d;
    logic [CAL_LOG2-1:0]  frame_cnt_q, frame_cnt_d;
    logic                 cal_last_s;

    logic [COORD_W-1:0]   left_s [NUM_STICKS];
    logic [COORD_W-1:0]   top_s  [NUM_STICKS];

    logic [NUM_STICKS-1:0] hit_s, hit_q;
    logic                  win_found_s;
    logic [11:0]           win_color_s;
    logic                  pixel_on_d, in_cutout_d;
    logic [11:0]           rgb_d;

    assign cal_last_s = (state_q == ST_CAL_ACC) && frame_start &&
                        (frame_cnt_q == {CAL_LOG2{1'b1}});

    // Calibration FSM state register; reset lands in CAL_WAIT to auto-calibrate
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CAL_WAIT;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Calibration FSM next state; cal_req only matters in RUN
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (cal_req) begin
                    state_d = ST_CAL_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_CAL_WAIT: begin
                if (frame_start) begin
                    state_d     = ST_CAL_ACC;
                    frame_cnt_d = '0;
                end else begin
                    state_d = ST_CAL_WAIT;
                end
            end
            ST_CAL_ACC: begin
                if (cal_last_s) begin
                    state_d     = ST_RUN;
                    frame_cnt_d = '0;
                end else if (frame_start) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end else begin
                    state_d = ST_CAL_ACC;
                end
            end
            default: begin
                state_d     = ST_CAL_WAIT;
                frame_cnt_d = '0;
            end
        endcase
    end

    // Calibration FSM outputs
    always_comb begin
        cal_busy = (state_q != ST_RUN);
    end

    for (genvar g = 0; g < NUM_STICKS; g++) begin : g_stick
        stick_axis_offset #(
            .AXIS_W      (AXIS_W),
            .DEADZONE    (DEADZONE),
            .MAX_OFF     (MAX_OFF),
            .CAL_LOG2    (CAL_LOG2),
            .HOME        (`SO_FIELD10(HOME_X_VEC, g)),
            .NEG_ON_HIGH (1'b0)
        ) u_axis_x (
            .clk           (clk),
            .reset         (reset),
            .frame_start_i (frame_start),
            .state_i       (state_q),
            .cal_last_i    (cal_last_s),
            .raw_i         (stick_x[g*AXIS_W +: AXIS_W]),
            .pos_o         (left_s[g])
        );

        stick_axis_offset #(
            .AXIS_W      (AXIS_W),
            .DEADZONE    (DEADZONE),
            .MAX_OFF     (MAX_OFF),
            .CAL_LOG2    (CAL_LOG2),
            .HOME        (`SO_FIELD10(HOME_Y_VEC, g)),
            .NEG_ON_HIGH (1'b1)
        ) u_axis_y (
            .clk           (clk),
            .reset         (reset),
            .frame_start_i (frame_start),
            .state_i       (state_q),
            .cal_last_i    (cal_last_s),
            .raw_i         (stick_y[g*AXIS_W +: AXIS_W]),
            .pos_o         (top_s[g])
        );
    end

    // Stage 0: sprite hit test and ROM addressing, widened to 11 bits so the far edge cannot wrap
    always_comb begin
        hit_s   = '0;
        rom_col = '0;
        rom_row = '0;
        for (int i = 0; i < NUM_STICKS; i++) begin
            hit_s[i] = ({1'b0, x} >= {1'b0, left_s[i]}) &&
                       ({1'b0, x} <  ({1'b0, left_s[i]} + {1'b0, `SO_FIELD10(SPR_W_VEC, i)})) &&
                       ({1'b0, y} >= {1'b0, top_s[i]}) &&
                       ({1'b0, y} <  ({1'b0, top_s[i]} + {1'b0, `SO_FIELD10(SPR_H_VEC, i)}));
            rom_col[i*COORD_W +: COORD_W] = x - left_s[i];
            rom_row[i*COORD_W +: COORD_W] = y - top_s[i];
        end
    end

    // Stage 0 register: hits line up with the ROM data returned one clock later
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_s;
        end
    end

    // Stage 1: lowest-index opaque hit wins; a CUTOUT winner hides everything beneath it
    always_comb begin
        win_found_s = 1'b0;
        win_color_s = 12'h000;
        for (int i = NUM_STICKS - 1; i >= 0; i--) begin
            if (hit_q[i] && (rom_data[i*12 +: 12] != TRANSPARENT)) begin
                win_found_s = 1'b1;
                win_color_s = rom_data[i*12 +: 12];
            end else begin
                win_found_s = win_found_s;
            end
        end
        in_cutout_d = win_found_s && (win_color_s == CUTOUT);
        pixel_on_d  = win_found_s && (win_color_s != CUTOUT);
        if (pixel_on_d) begin
            rgb_d = win_color_s;
        end else begin
            rgb_d = 12'h000;
        end
    end

    // Registered pixel outputs, two clocks after x/y
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_on  <= 1'b0;
            in_cutout <= 1'b0;
            rgb       <= 12'h000;
        end else begin
            pixel_on  <= pixel_on_d;
            in_cutout <= in_cutout_d;
            rgb       <= rgb_d;
        end
    end

endmodule
